// File: rtl/stall_ctrl.sv
// stall_ctrl: decode-stage stall counter; load-use detection compiled in with STALL_CTRL_LOADUSE_EN
module stall_ctrl #(
  parameter int CNT_W     = 6,
  parameter int BR_SLOTS  = 3,
  parameter int J_SLOTS   = 3,
  parameter int JR_SLOTS  = 3,
  parameter int DIV_SLOTS = 34,
  parameter int LU_SLOTS  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  input  logic             flush,
  input  logic             div_done,
  output logic             en_reg,
  output logic             nop,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int MAX = (1 << CNT_W) - 1;
  if (BR_SLOTS > MAX || J_SLOTS > MAX || JR_SLOTS > MAX || DIV_SLOTS > MAX || LU_SLOTS > MAX) begin : g_bad
    $error("stall_ctrl: slot parameter exceeds counter range");
  end
  logic [5:0] op, fn;
  logic [CNT_W-1:0] cnt, cnt_nx, slots, load_cnt;
  logic hold, is_div, cls_hold, cls_div, is_jr, accept, load_lu;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign accept = instr_valid && cnt == '0 && !flush;
  always_comb begin
    is_jr = op == 6'd0 && fn == 6'd8;
    cls_div = op == 6'd0 && (fn == 6'd27 || fn == 6'd25);
    cls_hold = op == 6'd2 || op == 6'd3 || is_jr;
    slots = (op == 6'd4 || op == 6'd5) ? CNT_W'(BR_SLOTS) :
            (op == 6'd2 || op == 6'd3) ? CNT_W'(J_SLOTS) :
            is_jr ? CNT_W'(JR_SLOTS) :
            cls_div ? CNT_W'(DIV_SLOTS) : '0;
  end
`ifdef STALL_CTRL_LOADUSE_EN
  // lw_rt holds the destination of the last accepted LW (0 = none pending)
  logic [4:0] lw_rt;
  logic [CNT_W:0] lu_sum;
  logic lock, unused_bits;
  assign unused_bits = ^instr[15:6];
  assign load_lu = lw_rt != 5'd0 && (instr[25:21] == lw_rt || instr[20:16] == lw_rt);
  assign lu_sum = {1'b0, slots} + (CNT_W + 1)'(LU_SLOTS);
  assign load_cnt = load_lu ? (lu_sum[CNT_W] ? '1 : lu_sum[CNT_W-1:0]) : slots;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lw_rt <= '0;
      lock <= 1'b0;
    end else if (accept) begin
      lw_rt <= op == 6'd35 ? instr[20:16] : 5'd0;
      lock <= load_lu;
    end
  end
  assign en_reg = !(hold && cnt > CNT_W'(1)) && !(lock && cnt != '0);
`else
  logic unused_bits;
  assign unused_bits = ^instr[25:6];
  assign load_lu = 1'b0;
  assign load_cnt = slots;
  assign en_reg = !(hold && cnt > CNT_W'(1));
`endif
  always_comb
    cnt_nx = flush ? '0 :
             cnt != '0 ? ((div_done && is_div) ? '0 : cnt - 1'b1) :
             instr_valid ? load_cnt : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      hold <= 1'b0;
      is_div <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      if (accept) begin
        hold <= cls_hold || load_lu;
        is_div <= cls_div && !load_lu;
      end
    end
  end
  assign nop = cnt != '0;
  assign busy = cnt != '0;
  assign stall_cnt = cnt;
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed table, corner sequences and random traffic against a schedule-based model
module tb_stall_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] instr;
  logic instr_valid, flush, div_done;
  logic en_reg, nop, busy;
  logic [5:0] stall_cnt;
  int n_chk = 0, n_fail = 0;

  stall_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .flush(flush), .div_done(div_done), .en_reg(en_reg), .nop(nop),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] BEQ  = 32'h1022_0003;
  localparam logic [31:0] BNE  = 32'h1422_0003;
  localparam logic [31:0] JMP  = 32'h0800_0010;
  localparam logic [31:0] JR   = 32'h03E0_0008;
  localparam logic [31:0] DIVU = 32'h0085_001B;
  localparam logic [31:0] LW   = 32'h8C02_0000;
  localparam logic [31:0] ADD  = 32'h0042_1820;

  // The model is a queue of per-cycle expected outputs scheduled at acceptance.
  typedef struct packed {logic en; logic [6:0] cnt;} slot_t;
  slot_t q[$];
  bit m_div;
  logic [4:0] m_lw_rt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_div = 0;
    m_lw_rt = 0;
  endtask

  task automatic model_edge(input logic [31:0] i, input bit v, input bit f, input bit d);
    int n;
    bit hold, dv, lu;
    logic [5:0] op, fn;
    if (f) q.delete();
    else if (q.size() != 0) begin
      if (d && m_div) q.delete();
      else void'(q.pop_front());
    end else if (v) begin
      op = i[31:26]; fn = i[5:0];
      n = 0; hold = 0; dv = 0; lu = 0;
      if (op == 4 || op == 5) n = 3;
      else if (op == 2 || op == 3) begin n = 3; hold = 1; end
      else if (op == 0 && fn == 8) begin n = 3; hold = 1; end
      else if (op == 0 && (fn == 27 || fn == 25)) begin n = 34; dv = 1; end
`ifdef STALL_CTRL_LOADUSE_EN
      if (m_lw_rt != 0 && (i[25:21] == m_lw_rt || i[20:16] == m_lw_rt)) begin
        n = (n + 1 > 63) ? 63 : n + 1;
        lu = 1;
      end
`endif
      m_lw_rt = (op == 35) ? i[20:16] : 5'd0;
      m_div = dv && !lu;
      for (int k = 0; k < n; k++) q.push_back('{en: !(lu || (hold && n - k > 1)), cnt: 7'(n - k)});
    end
  endtask

  task automatic cmp_model(input string tag);
    logic [31:0] ec, ee;
    ec = q.size() != 0 ? 32'(q[0].cnt) : 0;
    ee = q.size() != 0 ? 32'(q[0].en) : 1;
    check({tag, "_nop"}, 32'(nop), 32'(ec != 0));
    check({tag, "_busy"}, 32'(busy), 32'(ec != 0));
    check({tag, "_en"}, 32'(en_reg), ee);
    check({tag, "_cnt"}, 32'(stall_cnt), ec);
  endtask

  task automatic step(input string tag, input logic [31:0] i, input bit v, input bit f, input bit d);
    instr = i; instr_valid = v; flush = f; div_done = d;
    model_edge(i, v, f, d);
    @(posedge clk);
    #1;
    instr_valid = 0; flush = 0; div_done = 0;
    cmp_model(tag);
  endtask

  typedef struct {
    logic [31:0] instr;
    bit v, f, d, nop, en;
    int cnt;
  } vec_t;
  vec_t tbl[18];

  initial begin
    logic [31:0] ri;
    logic [5:0] op, fn;
    tbl[0]  = '{BEQ, 1, 0, 0, 1, 1, 3};
    tbl[1]  = '{0,   0, 0, 1, 1, 1, 2};
    tbl[2]  = '{0,   0, 0, 0, 1, 1, 1};
    tbl[3]  = '{0,   0, 0, 0, 0, 1, 0};
    tbl[4]  = '{JMP, 1, 0, 0, 1, 0, 3};
    tbl[5]  = '{BEQ, 1, 0, 0, 1, 0, 2};
    tbl[6]  = '{BEQ, 1, 0, 0, 1, 1, 1};
    tbl[7]  = '{0,   0, 0, 0, 0, 1, 0};
    tbl[8]  = '{JMP, 1, 0, 0, 1, 0, 3};
    tbl[9]  = '{0,   0, 0, 0, 1, 0, 2};
    tbl[10] = '{0,   0, 1, 0, 0, 1, 0};
    tbl[11] = '{BEQ, 1, 1, 0, 0, 1, 0};
    tbl[12] = '{ADD, 1, 0, 0, 0, 1, 0};
    tbl[13] = '{JR,  1, 0, 0, 1, 0, 3};
    tbl[14] = '{0,   0, 0, 0, 1, 0, 2};
    tbl[15] = '{0,   0, 0, 0, 1, 1, 1};
    tbl[16] = '{0,   0, 0, 0, 0, 1, 0};
    tbl[17] = '{BNE, 1, 0, 1, 1, 1, 3};
    reset = 0; instr = 0; instr_valid = 0; flush = 0; div_done = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_nop", 32'(nop), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_en", 32'(en_reg), 1);
    check("rst_cnt", 32'(stall_cnt), 0);
    reset = 1;
    for (int i = 0; i < 18; i++) begin
      step("tbl", tbl[i].instr, tbl[i].v, tbl[i].f, tbl[i].d);
      check($sformatf("tbl%0d_nop", i), 32'(nop), 32'(tbl[i].nop));
      check($sformatf("tbl%0d_en", i), 32'(en_reg), 32'(tbl[i].en));
      check($sformatf("tbl%0d_cnt", i), 32'(stall_cnt), 32'(tbl[i].cnt));
    end
    repeat (3) step("drain", 0, 0, 0, 0);
    // DIVU: early completion signalled in stall cycle 10
    step("div", DIVU, 1, 0, 0);
    check("div_load", 32'(stall_cnt), 34);
    repeat (9) step("div", 0, 0, 0, 0);
    check("div_c10_cnt", 32'(stall_cnt), 25);
    check("div_c10_en", 32'(en_reg), 1);
    step("div", 0, 0, 0, 1);
    check("div_done_nop", 32'(nop), 0);
    check("div_done_cnt", 32'(stall_cnt), 0);
    // asynchronous reset in cycle 5 of a DIVU stall
    step("rdiv", DIVU, 1, 0, 0);
    repeat (4) step("rdiv", 0, 0, 0, 0);
    check("rdiv_c5_cnt", 32'(stall_cnt), 30);
    #3 reset = 0;
    model_reset();
    #1;
    check("arst_nop", 32'(nop), 0);
    check("arst_en", 32'(en_reg), 1);
    check("arst_cnt", 32'(stall_cnt), 0);
    @(posedge clk);
    #2 reset = 1;
    step("post_rst", BEQ, 1, 0, 0);
    check("post_rst_cnt", 32'(stall_cnt), 3);
    repeat (3) step("drain", 0, 0, 0, 0);
    // load followed by a dependent ADD
    step("lw", LW, 1, 0, 0);
    check("lw_cnt", 32'(stall_cnt), 0);
    step("lu", ADD, 1, 0, 0);
`ifdef STALL_CTRL_LOADUSE_EN
    check("lu_nop", 32'(nop), 1);
    check("lu_en", 32'(en_reg), 0);
    check("lu_cnt", 32'(stall_cnt), 1);
`else
    check("lu_nop", 32'(nop), 0);
    check("lu_en", 32'(en_reg), 1);
    check("lu_cnt", 32'(stall_cnt), 0);
`endif
    step("lu_after", 0, 0, 0, 0);
    check("lu_after_nop", 32'(nop), 0);
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 9))
        0: begin op = 4; fn = 6'($urandom); end
        1: begin op = 5; fn = 6'($urandom); end
        2: begin op = 2; fn = 6'($urandom); end
        3: begin op = 3; fn = 6'($urandom); end
        4: begin op = 0; fn = 8; end
        5: begin op = 0; fn = 27; end
        6: begin op = 0; fn = 25; end
        7: begin op = 35; fn = 6'($urandom); end
        8: begin op = 0; fn = 32; end
        default: begin op = 6'($urandom); fn = 6'($urandom); end
      endcase
      ri = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 10'($urandom), fn};
      step("rnd", ri, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, 6, stall counter width in bits.
REQ-002 SHALL have parameter BR_SLOTS, 3, NOP cycles after BEQ (op 4) or BNE (op 5).
REQ-003 SHALL have parameter J_SLOTS, 3, NOP cycles after J (op 2) or JAL (op 3).
REQ-004 SHALL have parameter JR_SLOTS, 3, NOP cycles after JR (op 0, funct 8).
REQ-005 SHALL have parameter DIV_SLOTS, 34, NOP cycles after DIVU (op 0, funct 27) or MULTU (op 0, funct 25).
REQ-006 SHALL have parameter LU_SLOTS, 1, extra NOP cycles on a load-use hazard (see REQ-023).
REQ-007 SHALL have port clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port instr  input  32  instruction in decode.
REQ-010 SHALL have port instr_valid  input  1  instr is valid this cycle.
REQ-011 SHALL have port flush  input  1  synchronous cancel of any stall in progress.
REQ-012 SHALL have port div_done  input  1  divider finished early.
REQ-013 SHALL have ports en_reg (output, 1, PC/IF-ID write enable), nop (output, 1, insert bubble), busy (output, 1, stall active) and stall_cnt (output, CNT_W, remaining stall cycles).

Function
REQ-014 SHALL hold a registered counter cnt; nop = busy = (cnt != 0); stall_cnt = cnt; all outputs SHALL be register-driven or decoded only from registers.
REQ-015 SHALL accept instr on a rising edge only when instr_valid=1, cnt=0 and flush=0; the accepted instruction's class slot count is loaded into cnt on that edge.
REQ-016 SHALL assert nop for exactly N cycles after acceptance for a class of N slots, then accept the next instruction on the edge at which cnt=0.
REQ-017 SHALL treat a class parameter of 0, and every unlisted opcode/funct, as no stall: cnt stays 0, en_reg stays 1.
REQ-018 SHALL classify as HOLD the J/JAL/JR classes: en_reg=0 while cnt>1, en_reg=1 when cnt=1 or cnt=0.
REQ-019 SHALL classify as FLOW the branch and DIV classes: en_reg=1 throughout the stall.
REQ-020 SHALL decrement cnt by 1 on every edge while cnt!=0, independent of instr_valid.
REQ-021 SHALL, when flush=1 on an edge, set cnt to 0 and en_reg to 1; flush wins over simultaneous acceptance (instruction dropped).
REQ-022 SHALL, when div_done=1 on an edge during a DIV-class stall, set cnt to 0; div_done SHALL be ignored in any other class.
REQ-023 SHALL, with the Configuration feature enabled, detect a load-use hazard when the previously accepted instruction was LW (op 35) with rt!=0 and the newly accepted instruction's rs or rt equals that rt.
REQ-024 SHALL, on a load-use hazard, load cnt with class slots + LU_SLOTS, saturated at 2^CNT_W-1, and treat the stall as HOLD.
REQ-025 SHALL require every slot parameter <= 2^CNT_W-1, and SHALL raise an elaboration-time error otherwise.

Reset
REQ-026 SHALL, while reset=0, asynchronously force cnt=0, nop=0, busy=0, stall_cnt=0, en_reg=1, class=none and clear load-use tracking.
REQ-027 SHALL abandon any stall in progress when reset asserts mid-operation, and SHALL accept a new instruction on the first rising edge after reset deasserts.

Configuration
REQ-028 SHALL compile load-use detection (REQ-023, REQ-024) only when macro STALL_CTRL_LOADUSE_EN is defined.
REQ-029 SHALL, without STALL_CTRL_LOADUSE_EN, keep the same port list, contain no LW tracking registers and never add LU_SLOTS.

Verification
REQ-030 SHALL cover: BEQ 32'h1022_0003 accepted -> nop=1 for 3 cycles, en_reg=1 throughout, stall_cnt 3,2,1,0, next instr accepted.
REQ-031 SHALL cover: J 32'h0800_0010 -> nop=1 for 3 cycles, en_reg=0,0,1, then idle with en_reg=1.
REQ-032 SHALL cover: DIVU 32'h0085_001B -> stall_cnt loads 34; div_done pulsed in stall cycle 10 -> nop=0 from cycle 11.
REQ-033 SHALL cover: flush in cycle 2 of a J stall -> nop=0 and en_reg=1 next cycle; flush with instr_valid on BEQ -> no stall.
REQ-034 SHALL cover: reset driven low in cycle 5 of a DIVU stall -> nop=0, en_reg=1, stall_cnt=0 before the next clock edge.
REQ-035 SHALL cover: LW 32'h8C02_0000 then ADD 32'h0042_1820 -> 1 NOP with en_reg=0 when STALL_CTRL_LOADUSE_EN is defined; 0 NOPs when it is undefined.
